wb_arbiter: RTL and testbench

Writeback stage directly upstream of the register cells. Collects results from two execution sources (src0 = ALU, src1 = LSU) with valid/ready handshakes and arbitrates between them round-robin. Buffers accepted results in a small FIFO and emits at most one registered writeback per cycle (address, data, strobe). The register file decodes the strobe and address into per-cell wb_i / w_unreserve_i.

---
 rtl/wb_arbiter.sv | 104 ++++++++++
 tb/tb_wb_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Writeback arbiter: round-robin between ALU (src0) and LSU (src1) results,
// buffered in a small FIFO and drained as one registered writeback per cycle.
module wb_arbiter #(
   parameter int WORD  = 32,
   parameter int AW    = 5,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       s0_valid_i,
   input  logic [AW-1:0]              s0_addr_i,
   input  logic [WORD-1:0]            s0_data_i,
   output logic                       s0_ready_o,
   input  logic                       s1_valid_i,
   input  logic [AW-1:0]              s1_addr_i,
   input  logic [WORD-1:0]            s1_data_i,
   output logic                       s1_ready_o,
   output logic                       wb_o,
   output logic [AW-1:0]              wb_addr_o,
   output logic [WORD-1:0]            wb_data_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [AW-1:0]   r_mem_addr [DEPTH];
   logic [WORD-1:0] r_mem_data [DEPTH];
   logic [PW-1:0]   r_wr_ptr;
   logic [PW-1:0]   r_rd_ptr;
   logic [CW-1:0]   r_count;
   logic            r_prio;
   logic            r_wb;
   logic [AW-1:0]   r_wb_addr;
   logic [WORD-1:0] r_wb_data;

   logic            w_full;
   logic            w_empty;
   logic            w_grant0;
   logic            w_grant1;
   logic            w_push;
   logic            w_pop;
   logic [AW-1:0]   w_push_addr;
   logic [WORD-1:0] w_push_data;

   assign w_full  = (r_count == CW'(DEPTH));
   assign w_empty = (r_count == '0);

   // prio=0 favours src0 on contention; a lone valid source always wins
   always_comb begin
      w_grant0 = 1'b0;
      w_grant1 = 1'b0;
      if (!w_full) begin
         w_grant0 = s0_valid_i && (!s1_valid_i || !r_prio);
         w_grant1 = s1_valid_i && (!s0_valid_i ||  r_prio);
      end
   end

   assign w_push      = w_grant0 | w_grant1;
   assign w_pop       = !w_empty;
   assign w_push_addr = w_grant0 ? s0_addr_i : s1_addr_i;
   assign w_push_data = w_grant0 ? s0_data_i : s1_data_i;

   assign s0_ready_o = w_grant0;
   assign s1_ready_o = w_grant1;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_addr[r_wr_ptr] <= w_push_addr;
         r_mem_data[r_wr_ptr] <= w_push_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_count   <= '0;
         r_prio    <= 1'b0;
         r_wb      <= 1'b0;
         r_wb_addr <= '0;
         r_wb_data <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
            r_prio   <= w_grant0;
         end
         // pop reads the pre-edge head, so a fresh push is never bypassed
         if (w_pop) begin
            r_rd_ptr  <= r_rd_ptr + 1'b1;
            r_wb_addr <= r_mem_addr[r_rd_ptr];
            r_wb_data <= r_mem_data[r_rd_ptr];
         end
         r_wb    <= w_pop;
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end

   assign wb_o      = r_wb;
   assign wb_addr_o = r_wb_addr;
   assign wb_data_o = r_wb_data;
   assign count_o   = r_count;

endmodule

// File: tb/tb_wb_arbiter.sv
// Randomized and directed bench for wb_arbiter against a queue-based model
// of acceptance order, round-robin priority and one-pop-per-cycle drain.
module tb_wb_arbiter;

   localparam int WORD  = 32;
   localparam int AW    = 5;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic            clk = 1'b0;
   logic            rst;
   logic            s0_valid_i, s1_valid_i;
   logic [AW-1:0]   s0_addr_i, s1_addr_i;
   logic [WORD-1:0] s0_data_i, s1_data_i;
   logic            s0_ready_o, s1_ready_o;
   logic            wb_o;
   logic [AW-1:0]   wb_addr_o;
   logic [WORD-1:0] wb_data_o;
   logic [CW-1:0]   count_o;

   wb_arbiter #(.WORD(WORD), .AW(AW), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .s0_valid_i(s0_valid_i), .s0_addr_i(s0_addr_i), .s0_data_i(s0_data_i), .s0_ready_o(s0_ready_o),
      .s1_valid_i(s1_valid_i), .s1_addr_i(s1_addr_i), .s1_data_i(s1_data_i), .s1_ready_o(s1_ready_o),
      .wb_o(wb_o), .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o), .count_o(count_o)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // reference model
   logic [AW+WORD-1:0] mq[$];
   logic               m_prio;
   logic               e_wb;
   logic [AW-1:0]      e_addr;
   logic [WORD-1:0]    e_data;
   logic [WORD-1:0]    seen[$];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_clear();
      mq.delete();
      m_prio = 1'b0;
      e_wb   = 1'b0;
      e_addr = '0;
      e_data = '0;
   endtask

   // one clock: drive at negedge, check readys, advance model at posedge, check outputs
   task automatic step(input logic v0, input logic [AW-1:0] a0, input logic [WORD-1:0] d0,
                       input logic v1, input logic [AW-1:0] a1, input logic [WORD-1:0] d1,
                       output logic g0, output logic g1);
      logic full;
      @(negedge clk);
      s0_valid_i = v0; s0_addr_i = a0; s0_data_i = d0;
      s1_valid_i = v1; s1_addr_i = a1; s1_data_i = d1;
      #1;
      full = (mq.size() >= DEPTH);
      g0 = !full && v0 && (!v1 || m_prio == 1'b0);
      g1 = !full && v1 && (!v0 || m_prio == 1'b1);
      chk("s0_ready", 64'(s0_ready_o), 64'(g0));
      chk("s1_ready", 64'(s1_ready_o), 64'(g1));
      @(posedge clk);
      if (mq.size() > 0) begin
         e_wb = 1'b1;
         {e_addr, e_data} = mq.pop_front();
      end else begin
         e_wb = 1'b0;
      end
      if (g0) begin mq.push_back({a0, d0}); m_prio = 1'b1; end
      else if (g1) begin mq.push_back({a1, d1}); m_prio = 1'b0; end
      #1;
      chk("wb_o", 64'(wb_o), 64'(e_wb));
      chk("wb_addr", 64'(wb_addr_o), 64'(e_addr));
      chk("wb_data", 64'(wb_data_o), 64'(e_data));
      chk("count", 64'(count_o), 64'(mq.size()));
      chk("count_le_depth", 64'(count_o <= CW'(DEPTH)), 64'd1);
      if (wb_o) seen.push_back(wb_data_o);
   endtask

   task automatic idle(input int n);
      logic g0, g1;
      for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0, '0, g0, g1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      s0_valid_i = 1'b0; s1_valid_i = 1'b0;
      #1;
      model_clear();
      chk("rst_wb", 64'(wb_o), 64'd0);
      chk("rst_count", 64'(count_o), 64'd0);
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      logic g0, g1;
      int i0, i1;
      logic [WORD-1:0] d0s[2];
      logic [WORD-1:0] d1s[2];
      rst = 1'b0;
      s0_valid_i = 1'b0; s0_addr_i = '0; s0_data_i = '0;
      s1_valid_i = 1'b0; s1_addr_i = '0; s1_data_i = '0;
      model_clear();
      #12;
      chk("por_wb", 64'(wb_o), 64'd0);
      chk("por_addr", 64'(wb_addr_o), 64'd0);
      chk("por_data", 64'(wb_data_o), 64'd0);
      chk("por_count", 64'(count_o), 64'd0);
      @(negedge clk);
      rst = 1'b1;

      // 1: idle after reset
      idle(5);

      // 2: single transfer
      step(1'b1, 5'd3, 32'hDEADBEEF, 1'b0, '0, '0, g0, g1);
      chk("t2_ready", 64'(g0), 64'd1);
      idle(1);
      chk("t2_wb", 64'(wb_o), 64'd1);
      chk("t2_addr", 64'(wb_addr_o), 64'd3);
      chk("t2_data", 64'(wb_data_o), 64'hDEADBEEF);
      idle(1);
      chk("t2_wb_off", 64'(wb_o), 64'd0);
      chk("t2_count", 64'(count_o), 64'd0);

      // 3: contention from reset priority
      do_reset();
      seen.delete();
      d0s[0] = 32'h10; d0s[1] = 32'h11;
      d1s[0] = 32'h20; d1s[1] = 32'h21;
      i0 = 0; i1 = 0;
      for (int c = 0; c < 4; c++) begin
         step(1'b1, 5'd1, d0s[i0 % 2], 1'b1, 5'd2, d1s[i1 % 2], g0, g1);
         chk("t3_alt", 64'(g0), 64'((c % 2) == 0));
         if (g0) i0++;
         if (g1) i1++;
      end
      idle(3);
      chk("t3_n", 64'(seen.size()), 64'd4);
      if (seen.size() == 4) begin
         chk("t3_o0", 64'(seen[0]), 64'h10);
         chk("t3_o1", 64'(seen[1]), 64'h20);
         chk("t3_o2", 64'(seen[2]), 64'h11);
         chk("t3_o3", 64'(seen[3]), 64'h21);
      end

      // 4: random sustained traffic, scoreboarded by the model
      i0 = 0;
      for (int c = 0; c < 200 && i0 < 16; c++) begin
         step(1'($urandom), 5'($urandom), $urandom, 1'($urandom), 5'($urandom), $urandom, g0, g1);
         if (g0 || g1) i0++;
      end
      chk("t4_accepted", 64'(i0), 64'd16);
      idle(3);
      chk("t4_drained", 64'(count_o), 64'd0);

      // 5: same-address ordering
      seen.delete();
      step(1'b0, '0, '0, 1'b1, 5'd5, 32'h1, g0, g1);
      step(1'b1, 5'd5, 32'h2, 1'b0, '0, '0, g0, g1);
      idle(3);
      chk("t5_n", 64'(seen.size()), 64'd2);
      if (seen.size() == 2) begin
         chk("t5_first", 64'(seen[0]), 64'h1);
         chk("t5_last", 64'(seen[1]), 64'h2);
      end

      // 6: reset in the middle of traffic
      for (int c = 0; c < 3; c++)
         step(1'b1, 5'(c), 32'hA0 + c, 1'b1, 5'(c + 8), 32'hB0 + c, g0, g1);
      do_reset();
      seen.delete();
      idle(5);
      chk("t6_no_stale", 64'(seen.size()), 64'd0);

      // extra random burst after reset
      for (int c = 0; c < 100; c++)
         step(1'($urandom), 5'($urandom), $urandom, 1'($urandom), 5'($urandom), $urandom, g0, g1);
      idle(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
